// File: rtl/param_tensor_core.sv
// param_tensor_core: DIM x DIM signed matmul / mac / add / relu engine.
// Writes LANES result elements per clock with optional saturation.
module param_tensor_core #(
   parameter int DIM        = 4,
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                             clock_in,
   input  logic                             reset_in,
   input  logic                             tensor_core_register_file_write_enable,
   input  logic                             should_start_tensor_core,
   input  logic [1:0]                       operation_select,
   input  logic [DIM*DIM*DATA_WIDTH-1:0]    tensor_core_input1,
   input  logic [DIM*DIM*DATA_WIDTH-1:0]    tensor_core_input2,
   input  logic [DIM*DIM*DATA_WIDTH-1:0]    tensor_core_input3,
   output logic [DIM*DIM*DATA_WIDTH-1:0]    tensor_core_output,
   output logic                             busy,
   output logic                             is_done_with_calculation,
   output logic                             result_valid,
   output logic                             overflow
);

   localparam int N  = DIM * DIM;
   localparam int DW = DATA_WIDTH;
   localparam int MW = N * DW;
   localparam int SW = 2 * DW + $clog2(DIM) + 2;
   localparam int EW = $clog2(N + 1);

   localparam logic signed [SW-1:0] MAXV =
      {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV =
      {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic {
      S_IDLE,
      S_COMPUTE
   } state_t;

   state_t          state_q;
   logic [EW-1:0]   e_q;
   logic [1:0]      op_q;
   logic [MW-1:0]   a_q, b_q, c_q;
   logic [MW-1:0]   out_q, out_d;
   logic            busy_q, done_q, valid_q, ovf_q, ovf_d;

   logic signed [SW-1:0] full;
   logic signed [DW-1:0] nar;
   logic                 hi, lo;

   function automatic logic signed [DW-1:0] el(
      input logic [MW-1:0] m,
      input int            i
   );
      return m[i*DW +: DW];
   endfunction

   function automatic logic signed [SW-1:0] elem_full(
      input logic [1:0]    op,
      input logic [MW-1:0] a,
      input logic [MW-1:0] b,
      input logic [MW-1:0] c,
      input int            idx
   );
      int                   r;
      int                   col;
      logic signed [2*DW-1:0] p;
      logic signed [DW-1:0]   x;
      logic signed [SW-1:0]   acc;
      r   = idx / DIM;
      col = idx % DIM;
      acc = '0;
      p   = '0;
      x   = el(a, idx);
      case (op)
         2'b01: acc = SW'(el(a, idx)) + SW'(el(b, idx));
         2'b10: acc = x[DW-1] ? '0 : SW'(x);
         default: begin
            for (int k = 0; k < DIM; k++) begin
               p   = el(a, r*DIM + k) * el(b, k*DIM + col);
               acc = acc + SW'(p);
            end
            if (op == 2'b11) acc = acc + SW'(el(c, idx));
         end
      endcase
      return acc;
   endfunction

   // Next batch of result elements and whether any of them overflowed.
   always_comb begin
      out_d = out_q;
      ovf_d = 1'b0;
      full  = '0;
      nar   = '0;
      hi    = 1'b0;
      lo    = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         full = elem_full(op_q, a_q, b_q, c_q, int'(e_q) + l);
         hi   = full > MAXV;
         lo   = full < MINV;
         if (SATURATE && hi)      nar = MAXV[DW-1:0];
         else if (SATURATE && lo) nar = MINV[DW-1:0];
         else                     nar = full[DW-1:0];
         ovf_d = ovf_d | hi | lo;
         out_d[(int'(e_q) + l)*DW +: DW] = nar;
      end
   end

   // Control FSM with operand capture and registered status outputs.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q <= S_IDLE;
         e_q     <= '0;
         op_q    <= 2'b00;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (tensor_core_register_file_write_enable) begin
                  valid_q <= 1'b0;
               end else if (should_start_tensor_core) begin
                  a_q     <= tensor_core_input1;
                  b_q     <= tensor_core_input2;
                  c_q     <= tensor_core_input3;
                  op_q    <= operation_select;
                  e_q     <= '0;
                  valid_q <= 1'b0;
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               if (tensor_core_register_file_write_enable) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  out_q <= out_d;
                  ovf_q <= ovf_q | ovf_d;
                  if (e_q == EW'(N - LANES)) begin
                     e_q     <= '0;
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     valid_q <= 1'b1;
                  end else begin
                     e_q <= e_q + EW'(LANES);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tensor_core_output       = out_q;
   assign busy                     = busy_q;
   assign is_done_with_calculation = done_q;
   assign result_valid             = valid_q;
   assign overflow                 = ovf_q;

endmodule
